hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core, working with the EX/MEM forwarding unit.

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: resolves load-use, memory-ack wait and taken-branch
// redirect into per-stage stall, bubble and flush controls for the 5-stage core.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT  = 16,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_is_load_i,
   input  logic             ex_branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             stall_if_o,
   output logic             stall_id_o,
   output logic             stall_ex_o,
   output logic             stall_mem_o,
   output logic             bubble_ex_o,
   output logic             bubble_wb_o,
   output logic             flush_if_o,
   output logic             flush_id_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TO_LAST_I);
   localparam logic [1:0]        FC_LAST = 2'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [1:0]        flush_cnt, flush_nxt;

   logic lu, mw, to, run_eval;

   assign lu = ex_is_load_i && (ex_rd_i != 5'd0) &&
               ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
   assign mw = mem_req_i && !mem_ack_i;
   assign to = (MEM_TIMEOUT != 0) && mw && (wait_cnt == TO_LAST);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      flush_nxt   = flush_cnt;
      run_eval    = 1'b0;
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      bubble_ex_o = 1'b0;
      bubble_wb_o = 1'b0;
      flush_if_o  = 1'b0;
      flush_id_o  = 1'b0;
      mem_err_o   = 1'b0;

      // Controls stay low for as long as reset is held, independent of the clock.
      if (rst_ni) begin
         if (mw && !to) begin
            // A pending data-bus wait freezes the whole pipe in every state.
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            stall_mem_o = 1'b1;
            bubble_wb_o = 1'b1;
            flush_nxt   = 2'd0;
            state_nxt   = MEM_WAIT;
            wait_nxt    = (state == MEM_WAIT) ? wait_cnt + WAIT_W'(1) : WAIT_W'(1);
         end else if (to) begin
            mem_err_o = 1'b1;
            wait_nxt  = '0;
            flush_nxt = 2'd0;
            state_nxt = RUN;
         end else begin
            case (state)
               MEM_WAIT: begin
                  wait_nxt  = '0;
                  state_nxt = RUN;
                  run_eval  = 1'b1;
               end
               FLUSH: begin
                  flush_if_o = 1'b1;
                  flush_id_o = 1'b1;
                  if (flush_cnt == FC_LAST) begin
                     flush_nxt = 2'd0;
                     state_nxt = RUN;
                  end else begin
                     flush_nxt = flush_cnt + 2'd1;
                  end
               end
               default: run_eval = 1'b1;
            endcase
         end

         // Branch/load-use resolution shared by RUN and the ack cycle of MEM_WAIT.
         if (run_eval) begin
            if (ex_branch_taken_i) begin
               flush_if_o = 1'b1;
               flush_id_o = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  flush_nxt = 2'd1;
                  state_nxt = FLUSH;
               end
            end else if (lu) begin
               stall_if_o  = 1'b1;
               stall_id_o  = 1'b1;
               bubble_ex_o = 1'b1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= RUN;
         wait_cnt    <= '0;
         flush_cnt   <= 2'd0;
         stall_cnt_o <= '0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         flush_cnt <= flush_nxt;
         if (stall_if_o && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance a uses MEM_TIMEOUT=8/FLUSH_CYCLES=3,
// instance b uses a disabled timeout, single-cycle flush and a 2-bit saturating counter.
module tb_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
   logic       id_use_rs1_i, id_use_rs2_i, ex_is_load_i, ex_branch_taken_i;
   logic       mem_req_i, mem_ack_i;

   logic        sif_a, sid_a, sex_a, smem_a, bex_a, bwb_a, fif_a, fid_a, err_a;
   logic        sif_b, sid_b, sex_b, smem_b, bex_b, bwb_b, fif_b, fid_b, err_b;
   logic [31:0] cnt_a;
   logic [1:0]  cnt_b;
   logic [8:0]  ctl_a, ctl_b;

   int checks   = 0;
   int failures = 0;
   int exp_a    = 0;
   int exp_b    = 0;

   // Bit order: stall_if stall_id stall_ex stall_mem bubble_ex bubble_wb flush_if flush_id mem_err
   localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] C_LU   = 9'b1_1_0_0_1_0_0_0_0;
   localparam logic [8:0] C_MW   = 9'b1_1_1_1_0_1_0_0_0;
   localparam logic [8:0] C_FL   = 9'b0_0_0_0_0_0_1_1_0;
   localparam logic [8:0] C_ERR  = 9'b0_0_0_0_0_0_0_0_1;

   assign ctl_a = {sif_a, sid_a, sex_a, smem_a, bex_a, bwb_a, fif_a, fid_a, err_a};
   assign ctl_b = {sif_b, sid_b, sex_b, smem_b, bex_b, bwb_b, fif_b, fid_b, err_b};

   always #5 clk_i = ~clk_i;

   hazard_ctrl #(.MEM_TIMEOUT(8), .FLUSH_CYCLES(3), .CNT_W(32)) u_dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
      .ex_branch_taken_i(ex_branch_taken_i),
      .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .stall_if_o(sif_a), .stall_id_o(sid_a), .stall_ex_o(sex_a), .stall_mem_o(smem_a),
      .bubble_ex_o(bex_a), .bubble_wb_o(bwb_a),
      .flush_if_o(fif_a), .flush_id_o(fid_a),
      .mem_err_o(err_a), .stall_cnt_o(cnt_a)
   );

   hazard_ctrl #(.MEM_TIMEOUT(0), .FLUSH_CYCLES(1), .CNT_W(2)) u_dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
      .ex_branch_taken_i(ex_branch_taken_i),
      .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .stall_if_o(sif_b), .stall_id_o(sid_b), .stall_ex_o(sex_b), .stall_mem_o(smem_b),
      .bubble_ex_o(bex_b), .bubble_wb_o(bwb_b),
      .flush_if_o(fif_b), .flush_id_o(fid_b),
      .mem_err_o(err_b), .stall_cnt_o(cnt_b)
   );

   function automatic logic [1:0] sat_b(input int v);
      return (v > 3) ? 2'd3 : 2'(v);
   endfunction

   task automatic idle();
      id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
      ex_rd_i = 5'd0; ex_is_load_i = 1'b0; ex_branch_taken_i = 1'b0;
      mem_req_i = 1'b0; mem_ack_i = 1'b0;
   endtask

   task automatic set_lu();
      ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      idle();
      set_lu();
      mem_req_i = 1'b1;
      #2;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin
         failures++;
         $display("FAIL reset_ctl: a=%b b=%b expected %b", ctl_a, ctl_b, C_NONE);
      end
      checks++;
      if (cnt_a !== 32'd0 || cnt_b !== 2'd0) begin
         failures++;
         $display("FAIL reset_cnt: a=%0d b=%0d expected 0", cnt_a, cnt_b);
      end
      step();
      rst_ni = 1'b1;
      idle();
      #1;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin
         failures++;
         $display("FAIL idle_ctl: a=%b b=%b expected %b", ctl_a, ctl_b, C_NONE);
      end
      step();
   endtask

   task automatic test_load_use();
      idle();
      set_lu();
      #1;
      checks++;
      if (ctl_a !== C_LU || ctl_b !== C_LU) begin
         failures++;
         $display("FAIL lu_rs1: a=%b b=%b expected %b", ctl_a, ctl_b, C_LU);
      end
      step();
      exp_a += 1; exp_b += 1;
      checks++;
      if (cnt_a !== 32'(exp_a) || cnt_b !== sat_b(exp_b)) begin
         failures++;
         $display("FAIL lu_cnt: a=%0d b=%0d expected %0d/%0d", cnt_a, cnt_b, exp_a, sat_b(exp_b));
      end
      // Match on rs2 only
      idle();
      ex_is_load_i = 1'b1; ex_rd_i = 5'd9; id_rs2_i = 5'd9; id_use_rs2_i = 1'b1; id_rs1_i = 5'd3;
      #1;
      checks++;
      if (ctl_a !== C_LU || ctl_b !== C_LU) begin
         failures++;
         $display("FAIL lu_rs2: a=%b b=%b expected %b", ctl_a, ctl_b, C_LU);
      end
      step();
      exp_a += 1; exp_b += 1;
      // x0 destination never creates a hazard
      idle();
      ex_is_load_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_use_rs1_i = 1'b1;
      #1;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin
         failures++;
         $display("FAIL lu_x0: a=%b b=%b expected %b", ctl_a, ctl_b, C_NONE);
      end
      step();
      // Matching register that is not read
      idle();
      set_lu();
      id_use_rs1_i = 1'b0;
      #1;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin
         failures++;
         $display("FAIL lu_unused: a=%b b=%b expected %b", ctl_a, ctl_b, C_NONE);
      end
      step();
      idle();
   endtask

   task automatic test_mem_wait();
      idle();
      mem_req_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         #1;
         checks++;
         if (ctl_a !== C_MW || ctl_b !== C_MW) begin
            failures++;
            $display("FAIL mw_cycle%0d: a=%b b=%b expected %b", i, ctl_a, ctl_b, C_MW);
         end
         step();
      end
      mem_ack_i = 1'b1;
      #1;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin
         failures++;
         $display("FAIL mw_ack: a=%b b=%b expected %b", ctl_a, ctl_b, C_NONE);
      end
      step();
      idle();
      exp_a += 3; exp_b += 3;
      checks++;
      if (cnt_a !== 32'(exp_a) || cnt_b !== sat_b(exp_b)) begin
         failures++;
         $display("FAIL mw_cnt: a=%0d b=%0d expected %0d/%0d", cnt_a, cnt_b, exp_a, sat_b(exp_b));
      end
   endtask

   task automatic test_timeout();
      logic [8:0] want;
      idle();
      mem_req_i = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         want = (i == 8) ? C_ERR : C_MW;
         #1;
         checks++;
         if (ctl_a !== want || ctl_b !== C_MW) begin
            failures++;
            $display("FAIL to_cycle%0d: a=%b b=%b expected %b/%b", i, ctl_a, ctl_b, want, C_MW);
         end
         step();
      end
      mem_ack_i = 1'b1;
      #1;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin
         failures++;
         $display("FAIL to_ack: a=%b b=%b expected %b", ctl_a, ctl_b, C_NONE);
      end
      step();
      idle();
      exp_a += 8; exp_b += 9;
      checks++;
      if (cnt_a !== 32'(exp_a) || cnt_b !== sat_b(exp_b)) begin
         failures++;
         $display("FAIL to_cnt: a=%0d b=%0d expected %0d/%0d", cnt_a, cnt_b, exp_a, sat_b(exp_b));
      end
   endtask

   task automatic test_branch_in_wait();
      idle();
      mem_req_i = 1'b1;
      ex_branch_taken_i = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         #1;
         checks++;
         if (ctl_a !== C_MW || ctl_b !== C_MW) begin
            failures++;
            $display("FAIL br_wait%0d: a=%b b=%b expected %b", i, ctl_a, ctl_b, C_MW);
         end
         step();
      end
      mem_ack_i = 1'b1;
      #1;
      checks++;
      if (ctl_a !== C_FL || ctl_b !== C_FL) begin
         failures++;
         $display("FAIL br_ack: a=%b b=%b expected %b", ctl_a, ctl_b, C_FL);
      end
      step();
      idle();
      for (int i = 2; i <= 4; i++) begin
         #1;
         checks++;
         if (ctl_a !== ((i <= 3) ? C_FL : C_NONE) || ctl_b !== C_NONE) begin
            failures++;
            $display("FAIL br_flush%0d: a=%b b=%b", i, ctl_a, ctl_b);
         end
         step();
      end
      exp_a += 2; exp_b += 2;
   endtask

   task automatic test_flush_lu();
      idle();
      set_lu();
      ex_branch_taken_i = 1'b1;
      #1;
      checks++;
      if (ctl_a !== C_FL || ctl_b !== C_FL) begin
         failures++;
         $display("FAIL fl_lu1: a=%b b=%b expected %b", ctl_a, ctl_b, C_FL);
      end
      step();
      ex_branch_taken_i = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         #1;
         checks++;
         if (ctl_a !== ((i <= 3) ? C_FL : C_LU) || ctl_b !== C_LU) begin
            failures++;
            $display("FAIL fl_lu%0d: a=%b b=%b", i, ctl_a, ctl_b);
         end
         step();
      end
      idle();
      exp_a += 1; exp_b += 3;
      checks++;
      if (cnt_a !== 32'(exp_a) || cnt_b !== sat_b(exp_b)) begin
         failures++;
         $display("FAIL fl_cnt: a=%0d b=%0d expected %0d/%0d", cnt_a, cnt_b, exp_a, sat_b(exp_b));
      end
   endtask

   task automatic test_reset_mid();
      idle();
      mem_req_i = 1'b1;
      step();
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE || cnt_a !== 32'd0 || cnt_b !== 2'd0) begin
         failures++;
         $display("FAIL rst_mw: a=%b/%0d b=%b/%0d expected 0", ctl_a, cnt_a, ctl_b, cnt_b);
      end
      step();
      rst_ni = 1'b1;
      exp_a = 0; exp_b = 0;
      // Fresh wait starts from RUN with cleared counters
      #1;
      checks++;
      if (ctl_a !== C_MW || ctl_b !== C_MW) begin
         failures++;
         $display("FAIL rst_rel: a=%b b=%b expected %b", ctl_a, ctl_b, C_MW);
      end
      step();
      exp_a += 1; exp_b += 1;
      mem_ack_i = 1'b1;
      step();
      idle();
      checks++;
      if (cnt_a !== 32'(exp_a) || cnt_b !== sat_b(exp_b)) begin
         failures++;
         $display("FAIL rst_cnt: a=%0d b=%0d expected %0d/%0d", cnt_a, cnt_b, exp_a, sat_b(exp_b));
      end
      // Reset in FLUSH must not resume the flush
      ex_branch_taken_i = 1'b1;
      step();
      ex_branch_taken_i = 1'b0;
      #1;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (ctl_a !== C_NONE) begin
         failures++;
         $display("FAIL rst_fl: a=%b expected %b", ctl_a, C_NONE);
      end
      step();
      rst_ni = 1'b1;
      #1;
      checks++;
      if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin
         failures++;
         $display("FAIL rst_fl_rel: a=%b b=%b expected %b", ctl_a, ctl_b, C_NONE);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_branch_in_wait();
      test_flush_lu();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
